// File: rtl/sm_fv_bank_buffer.sv
// sm_fv_bank_buffer
// Captures one replay iteration of feature-value lines from the bank
// controller stream into a local flop buffer, then serves per-node read
// bursts to the Edge PEs as tagged sos/eos response streams. A new incoming
// stream always preempts any read activity.
module sm_fv_bank_buffer #(
  parameter int FV_BW          = 32,
  parameter int DEPTH          = 64,
  parameter int LINES_PER_NODE = 8,
  parameter int NUM_PE         = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int NW = $clog2(DEPTH / LINES_PER_NODE),
  localparam int LB = $clog2(LINES_PER_NODE),
  localparam int LW = LB + 1,
  localparam int TW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_sos,
  input  logic             in_eos,
  input  logic [FV_BW-1:0] in_data,
  input  logic [AW-1:0]    in_addr,
  input  logic             rd_req_valid,
  output logic             rd_req_ready,
  input  logic [NW-1:0]    rd_node,
  input  logic [LW-1:0]    rd_len,
  input  logic [TW-1:0]    rd_pe_tag,
  output logic             rd_out_valid,
  output logic             rd_out_sos,
  output logic             rd_out_eos,
  output logic [FV_BW-1:0] rd_out_data,
  output logic [TW-1:0]    rd_out_pe_tag,
  output logic             fill_done,
  output logic             buf_valid,
  output logic             overrun_err
);

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    READY,
    SERVE
  } state_t;

  state_t state, state_next;

  logic [FV_BW-1:0] mem [DEPTH];

  logic [AW-1:0] base_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] cnt_q;

  logic          write_en;
  logic          fill_end;
  logic          accept;
  logic          overrun_hit;
  logic [LW-1:0] len_eff;
  logic [AW-1:0] req_base;

  // Request decode: a zero or oversized length means "whole node slot", and
  // the node index maps to the first line of its slot.
  always_comb begin
    len_eff  = rd_len;
    if (rd_len == '0 || rd_len > LW'(LINES_PER_NODE)) begin
      len_eff = LW'(LINES_PER_NODE);
    end
    req_base = AW'({rd_node, {LB{1'b0}}});
  end

  // Next-state and control: fills beat reads, and the burst ends after the
  // cycle that shows the eos line.
  always_comb begin
    state_next   = state;
    write_en     = 1'b0;
    fill_end     = 1'b0;
    accept       = 1'b0;
    overrun_hit  = 1'b0;
    rd_req_ready = (state == READY) && !in_sos;
    case (state)
      EMPTY, READY: begin
        if (in_sos) begin
          write_en   = 1'b1;
          fill_end   = in_eos;
          state_next = in_eos ? READY : FILL;
        end else if (state == READY && rd_req_valid) begin
          accept     = 1'b1;
          state_next = SERVE;
        end
      end
      FILL: begin
        write_en = 1'b1;
        if (in_eos) begin
          fill_end   = 1'b1;
          state_next = READY;
        end
      end
      SERVE: begin
        if (in_sos) begin
          write_en    = 1'b1;
          overrun_hit = 1'b1;
          fill_end    = in_eos;
          state_next  = in_eos ? READY : FILL;
        end else if (rd_out_eos) begin
          state_next = READY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Line storage is deliberately not reset; contents are only meaningful
  // once a stream has completed.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[in_addr] <= in_data;
    end
  end

  // Fill status flags: one-cycle completion pulse, buffer-valid level and
  // the sticky overrun indication.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_done   <= 1'b0;
      buf_valid   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      fill_done <= fill_end;
      if (fill_end) begin
        buf_valid <= 1'b1;
      end else if (write_en && in_sos) begin
        buf_valid <= 1'b0;
      end
      if (overrun_hit) begin
        overrun_err <= 1'b1;
      end
    end
  end

  // Burst engine: the accept edge loads line 0 straight into the registered
  // outputs, then each SERVE cycle advances one line until eos is shown. A
  // stream start during SERVE silently drops whatever is left.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q        <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      rd_out_valid  <= 1'b0;
      rd_out_sos    <= 1'b0;
      rd_out_eos    <= 1'b0;
      rd_out_data   <= '0;
      rd_out_pe_tag <= '0;
    end else if (accept) begin
      base_q        <= req_base;
      len_q         <= len_eff;
      cnt_q         <= LW'(1);
      rd_out_valid  <= 1'b1;
      rd_out_sos    <= 1'b1;
      rd_out_eos    <= (len_eff == LW'(1));
      rd_out_data   <= mem[req_base];
      rd_out_pe_tag <= rd_pe_tag;
    end else if (state == SERVE && !in_sos && !rd_out_eos) begin
      cnt_q        <= cnt_q + LW'(1);
      rd_out_valid <= 1'b1;
      rd_out_sos   <= 1'b0;
      rd_out_eos   <= (cnt_q == len_q - LW'(1));
      rd_out_data  <= mem[base_q + AW'(cnt_q)];
    end else begin
      rd_out_valid <= 1'b0;
      rd_out_sos   <= 1'b0;
      rd_out_eos   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sm_fv_bank_buffer.sv
// Self-checking bench for sm_fv_bank_buffer: expected response lines are
// pushed to a scoreboard queue when a request is issued and compared against
// the lines the DUT actually emits.
module tb_sm_fv_bank_buffer;

  localparam int FV_BW = 32;
  localparam int DEPTH = 64;
  localparam int LPN   = 8;
  localparam int AW    = 6;
  localparam int NW    = 3;
  localparam int LW    = 4;
  localparam int TW    = 2;

  typedef struct packed {
    logic             sos;
    logic             eos;
    logic [FV_BW-1:0] data;
    logic [TW-1:0]    tag;
  } line_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_sos;
  logic             in_eos;
  logic [FV_BW-1:0] in_data;
  logic [AW-1:0]    in_addr;
  logic             rd_req_valid;
  logic             rd_req_ready;
  logic [NW-1:0]    rd_node;
  logic [LW-1:0]    rd_len;
  logic [TW-1:0]    rd_pe_tag;
  logic             rd_out_valid;
  logic             rd_out_sos;
  logic             rd_out_eos;
  logic [FV_BW-1:0] rd_out_data;
  logic [TW-1:0]    rd_out_pe_tag;
  logic             fill_done;
  logic             buf_valid;
  logic             overrun_err;

  int checks = 0;
  int fails  = 0;

  logic [FV_BW-1:0] model_mem [DEPTH];
  line_t exp_q[$];
  line_t obs_q[$];

  // Results reported by the stream and request tasks.
  int   fd_count;
  logic fd_end;
  logic fd_after;
  logic bv_end;
  logic rdy_end;
  logic bv_mid;
  logic ovr_mid;
  int   valid_seen;
  logic ready_seen;

  sm_fv_bank_buffer dut (
    .clk(clk),
    .reset(reset),
    .in_sos(in_sos),
    .in_eos(in_eos),
    .in_data(in_data),
    .in_addr(in_addr),
    .rd_req_valid(rd_req_valid),
    .rd_req_ready(rd_req_ready),
    .rd_node(rd_node),
    .rd_len(rd_len),
    .rd_pe_tag(rd_pe_tag),
    .rd_out_valid(rd_out_valid),
    .rd_out_sos(rd_out_sos),
    .rd_out_eos(rd_out_eos),
    .rd_out_data(rd_out_data),
    .rd_out_pe_tag(rd_out_pe_tag),
    .fill_done(fill_done),
    .buf_valid(buf_valid),
    .overrun_err(overrun_err)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Drive a full 64-line stream with data base+addr; sample status and any
  // response lines on each falling edge.
  task automatic stream_lines(input logic [FV_BW-1:0] base);
    fd_count   = 0;
    valid_seen = 0;
    for (int a = 0; a < DEPTH; a++) begin
      @(posedge clk); #1;
      in_sos  = (a == 0);
      in_eos  = (a == DEPTH - 1);
      in_addr = AW'(a);
      in_data = base + FV_BW'(a);
      model_mem[a] = base + FV_BW'(a);
      @(negedge clk);
      fd_count += int'(fill_done);
      if (rd_out_valid) begin
        valid_seen++;
        obs_q.push_back(line_t'{rd_out_sos, rd_out_eos, rd_out_data, rd_out_pe_tag});
      end
      if (a == 1) begin
        bv_mid  = buf_valid;
        ovr_mid = overrun_err;
      end
    end
    @(posedge clk); #1;
    in_sos = 1'b0;
    in_eos = 1'b0;
    @(negedge clk);
    fd_end   = fill_done;
    bv_end   = buf_valid;
    rdy_end  = rd_req_ready;
    fd_count += int'(fill_done);
    @(negedge clk);
    fd_after = fill_done;
    fd_count += int'(fill_done);
  endtask

  // Present one request for a cycle; returns after the accept edge.
  task automatic issue_req(input int node, input int len, input int tag);
    @(posedge clk); #1;
    rd_req_valid = 1'b1;
    rd_node      = NW'(node);
    rd_len       = LW'(len);
    rd_pe_tag    = TW'(tag);
    @(negedge clk);
    ready_seen = rd_req_ready;
    @(posedge clk); #1;
    rd_req_valid = 1'b0;
  endtask

  // Scoreboard push using the bench's own memory model and length clamp.
  task automatic push_burst(input int node, input int len, input int tag);
    int eff;
    eff = (len == 0 || len > LPN) ? LPN : len;
    for (int k = 0; k < eff; k++) begin
      exp_q.push_back(line_t'{(k == 0), (k == eff - 1), model_mem[node * LPN + k], TW'(tag)});
    end
  endtask

  // Gather response lines until eos or the cycle budget runs out.
  task automatic collect(input int budget, output int first_cyc, output int ready_hi);
    first_cyc = -1;
    ready_hi  = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (rd_out_valid) begin
        obs_q.push_back(line_t'{rd_out_sos, rd_out_eos, rd_out_data, rd_out_pe_tag});
        if (first_cyc < 0) first_cyc = i;
        if (rd_req_ready) ready_hi++;
        if (rd_out_eos) break;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (rd_req_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready: got %b, want 0", rd_req_ready); end
    checks++;
    if (rd_out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b, want 0", rd_out_valid); end
    checks++;
    if ({fill_done, buf_valid, overrun_err} !== 3'b000) begin
      fails++; $display("[TB] FAIL reset_flags: got %b, want 000", {fill_done, buf_valid, overrun_err});
    end
    checks++;
    if ({rd_out_sos, rd_out_eos, rd_out_data, rd_out_pe_tag} !== '0) begin
      fails++; $display("[TB] FAIL reset_outputs: got %h, want 0", {rd_out_sos, rd_out_eos, rd_out_data, rd_out_pe_tag});
    end
  endtask

  task automatic test_fill();
    stream_lines(32'hA000);
    checks++;
    if (fd_count !== 1) begin fails++; $display("[TB] FAIL fill_pulse_count: got %0d, want 1", fd_count); end
    checks++;
    if (fd_end !== 1'b1 || fd_after !== 1'b0) begin
      fails++; $display("[TB] FAIL fill_pulse_timing: got %b%b, want 10", fd_end, fd_after);
    end
    checks++;
    if (bv_end !== 1'b1) begin fails++; $display("[TB] FAIL fill_buf_valid: got %b, want 1", bv_end); end
    checks++;
    if (rdy_end !== 1'b1) begin fails++; $display("[TB] FAIL fill_ready: got %b, want 1", rdy_end); end
  endtask

  task automatic test_read_node3();
    int first, rdy;
    line_t e, o;
    push_burst(3, 8, 2);
    issue_req(3, 8, 2);
    checks++;
    if (ready_seen !== 1'b1) begin fails++; $display("[TB] FAIL n3_accept: got %b, want 1", ready_seen); end
    collect(12, first, rdy);
    checks++;
    if (first !== 1) begin fails++; $display("[TB] FAIL n3_latency: got %0d, want 1", first); end
    checks++;
    if (rdy !== 0) begin fails++; $display("[TB] FAIL n3_ready_in_burst: got %0d, want 0", rdy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        fails++; $display("[TB] FAIL n3_line: got none, want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("[TB] FAIL n3_line: got %h, want %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() !== 0) begin fails++; $display("[TB] FAIL n3_extra: got %0d, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_back_to_back();
    int first, rdy;
    line_t e, o;
    push_burst(7, 0, 1);
    issue_req(7, 0, 1);
    checks++;
    if (ready_seen !== 1'b1) begin fails++; $display("[TB] FAIL b2b_accept0: got %b, want 1", ready_seen); end
    collect(12, first, rdy);
    checks++;
    if (rdy !== 0) begin fails++; $display("[TB] FAIL b2b_bubble: got %0d, want 0", rdy); end
    push_burst(7, 1, 3);
    issue_req(7, 1, 3);
    checks++;
    if (ready_seen !== 1'b1) begin fails++; $display("[TB] FAIL b2b_accept1: got %b, want 1", ready_seen); end
    collect(4, first, rdy);
    checks++;
    if (first !== 1) begin fails++; $display("[TB] FAIL b2b_latency: got %0d, want 1", first); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        fails++; $display("[TB] FAIL b2b_line: got none, want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("[TB] FAIL b2b_line: got %h, want %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() !== 0) begin fails++; $display("[TB] FAIL b2b_extra: got %0d, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_overrun();
    int first, rdy;
    line_t e, o;
    exp_q.push_back(line_t'{1'b1, 1'b0, model_mem[8], 2'd0});
    exp_q.push_back(line_t'{1'b0, 1'b0, model_mem[9], 2'd0});
    issue_req(1, 8, 0);
    @(negedge clk);
    if (rd_out_valid) obs_q.push_back(line_t'{rd_out_sos, rd_out_eos, rd_out_data, rd_out_pe_tag});
    stream_lines(32'hB000);
    checks++;
    if (obs_q.size() !== 2) begin fails++; $display("[TB] FAIL ovr_line_count: got %0d, want 2", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        fails++; $display("[TB] FAIL ovr_line: got none, want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("[TB] FAIL ovr_line: got %h, want %h", o, e); end
      end
    end
    obs_q.delete();
    checks++;
    if (ovr_mid !== 1'b1 || overrun_err !== 1'b1) begin
      fails++; $display("[TB] FAIL ovr_flag: got %b%b, want 11", ovr_mid, overrun_err);
    end
    checks++;
    if (bv_mid !== 1'b0) begin fails++; $display("[TB] FAIL ovr_buf_valid_mid: got %b, want 0", bv_mid); end
    checks++;
    if (bv_end !== 1'b1 || fd_count !== 1) begin
      fails++; $display("[TB] FAIL ovr_refill: got bv=%b pulses=%0d, want bv=1 pulses=1", bv_end, fd_count);
    end
    push_burst(0, 8, 1);
    issue_req(0, 8, 1);
    collect(12, first, rdy);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        fails++; $display("[TB] FAIL ovr_read0: got none, want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("[TB] FAIL ovr_read0: got %h, want %h", o, e); end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_single_word();
    int first, rdy;
    line_t e, o;
    @(posedge clk); #1;
    in_sos  = 1'b1;
    in_eos  = 1'b1;
    in_addr = AW'(5);
    in_data = 32'hC005;
    model_mem[5] = 32'hC005;
    @(posedge clk); #1;
    in_sos = 1'b0;
    in_eos = 1'b0;
    @(negedge clk);
    checks++;
    if ({fill_done, buf_valid, rd_req_ready} !== 3'b111) begin
      fails++; $display("[TB] FAIL single_status: got %b, want 111", {fill_done, buf_valid, rd_req_ready});
    end
    @(negedge clk);
    checks++;
    if (fill_done !== 1'b0) begin fails++; $display("[TB] FAIL single_pulse_len: got %b, want 0", fill_done); end
    push_burst(0, 8, 2);
    issue_req(0, 8, 2);
    collect(12, first, rdy);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        fails++; $display("[TB] FAIL single_read: got none, want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("[TB] FAIL single_read: got %h, want %h", o, e); end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_async();
    int first, rdy;
    line_t e, o;
    issue_req(2, 8, 0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({rd_out_valid, rd_out_sos, rd_out_eos, rd_req_ready, buf_valid} !== 5'b0) begin
      fails++; $display("[TB] FAIL rst_burst: got %b, want 00000", {rd_out_valid, rd_out_sos, rd_out_eos, rd_req_ready, buf_valid});
    end
    @(posedge clk); #1 reset = 1'b0;
    // Partial fill, then reset in the middle of it.
    in_sos = 1'b1; in_addr = '0; in_data = 32'hE000;
    @(posedge clk); #1;
    in_sos = 1'b0; in_addr = AW'(1); in_data = 32'hE001;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({fill_done, buf_valid, rd_req_ready, overrun_err} !== 4'b0) begin
      fails++; $display("[TB] FAIL rst_fill: got %b, want 0000", {fill_done, buf_valid, rd_req_ready, overrun_err});
    end
    @(posedge clk); #1 reset = 1'b0;
    // Stray words without sos are ignored in EMPTY, even one carrying eos.
    for (int a = 2; a < 5; a++) begin
      in_addr = AW'(a);
      in_data = 32'hE000 + FV_BW'(a);
      in_eos  = (a == 4);
      @(posedge clk); #1;
    end
    in_eos = 1'b0;
    @(negedge clk);
    checks++;
    if ({rd_req_ready, buf_valid, fill_done} !== 3'b000) begin
      fails++; $display("[TB] FAIL rst_stray: got %b, want 000", {rd_req_ready, buf_valid, fill_done});
    end
    stream_lines(32'hD000);
    checks++;
    if (rdy_end !== 1'b1 || bv_end !== 1'b1) begin
      fails++; $display("[TB] FAIL rst_refill: got %b%b, want 11", rdy_end, bv_end);
    end
    obs_q.delete();
    push_burst(4, 9, 1);
    issue_req(4, 9, 1);
    collect(12, first, rdy);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        fails++; $display("[TB] FAIL clamp_read: got none, want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin fails++; $display("[TB] FAIL clamp_read: got %h, want %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() !== 0) begin fails++; $display("[TB] FAIL clamp_extra: got %0d, want 0", obs_q.size()); end
  endtask

  // Main sequence: reset, then each scenario in order, then the summary.
  initial begin
    reset        = 1'b1;
    in_sos       = 1'b0;
    in_eos       = 1'b0;
    in_data      = '0;
    in_addr      = '0;
    rd_req_valid = 1'b0;
    rd_node      = '0;
    rd_len       = '0;
    rd_pe_tag    = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_read_node3();
    test_back_to_back();
    test_overrun();
    test_single_word();
    test_reset_async();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
